// File: rtl/ahb_apb_pkg.sv
// Shared encodings, FSM state type and sizing helper for the multi-slave AHB-to-APB bridge.
package ahb_apb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WWAIT,
    ST_SETUP,
    ST_ACCESS,
    ST_ERR1,
    ST_ERR2
  } state_e;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ahb_apb_bridge_mc_decoder.sv
// Combinational slave decode: upper address field -> slave index, one-hot select and miss flag.
module apb_decoder
  import ahb_apb_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int NUM_SLAVES  = 4,
  parameter int SLV_SEL_LSB = 12,
  parameter int IDX_W       = idx_width(NUM_SLAVES)
) (
  input  logic [ADDR_W-1:SLV_SEL_LSB] Haddr,
  input  logic                        valid,
  output logic [IDX_W-1:0]            index,
  output logic [NUM_SLAVES-1:0]       sel,
  output logic                        miss
);

  localparam int FIELD_W = ADDR_W - SLV_SEL_LSB;
  // Compare in at least 5 bits so NUM_SLAVES=16 never truncates against a narrow field.
  localparam int CMP_W   = (FIELD_W > 5) ? FIELD_W : 5;

  logic [CMP_W-1:0] field;

  assign field = CMP_W'(Haddr);
  assign index = IDX_W'(Haddr);
  assign miss  = valid && (field >= CMP_W'(NUM_SLAVES));

  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      sel[i] = valid && !miss && (field == CMP_W'(i));
    end
  end

endmodule

// File: rtl/ahb_apb_bridge_mc.sv
// AHB-Lite to multi-slave APB bridge with PREADY waits, PSLVERR/decode-miss ERROR responses and an access timeout.
module ahb_apb_bridge_mc
  import ahb_apb_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int NUM_SLAVES  = 4,
  parameter int SLV_SEL_LSB = 12,
  parameter int TIMEOUT     = 16
) (
  input  logic                         Hclk,
  input  logic                         Hrst,
  input  logic                         Hsel_APB,
  input  logic [1:0]                   Htrans,
  input  logic                         Hwrite,
  input  logic [ADDR_W-1:0]            Haddr,
  input  logic [DATA_W-1:0]            Hwdata,
  output logic                         Hready_out,
  output logic [1:0]                   Hresp,
  output logic [DATA_W-1:0]            Hrdata,
  output logic [NUM_SLAVES-1:0]        Pselx,
  output logic                         Penable,
  output logic                         Pwrite,
  output logic [ADDR_W-1:0]            Paddr,
  output logic [DATA_W-1:0]            Pwdata,
  input  logic [NUM_SLAVES*DATA_W-1:0] Prdata,
  input  logic [NUM_SLAVES-1:0]        Pready,
  input  logic [NUM_SLAVES-1:0]        Pslverr
);

  localparam int IDX_W = idx_width(NUM_SLAVES);
  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  state_e                  state_q;
  logic [IDX_W-1:0]        idx_q;
  logic                    miss_q;
  logic [NUM_SLAVES-1:0]   sel_q;
  logic [NUM_SLAVES-1:0]   psel_q;
  logic                    penable_q;
  logic                    pwrite_q;
  logic [ADDR_W-1:0]       paddr_q;
  logic [DATA_W-1:0]       pwdata_q;
  logic [DATA_W-1:0]       hrdata_q;
  logic                    hready_q;
  logic [1:0]              hresp_q;
  logic [CNT_W-1:0]        tcnt_q;

  logic                    req_valid;
  logic                    accept;
  logic [IDX_W-1:0]        dec_idx;
  logic [NUM_SLAVES-1:0]   dec_sel;
  logic                    dec_miss;
  logic [DATA_W-1:0]       slv_rdata;
  logic                    slv_ready;
  logic                    slv_err;
  logic                    tmo_hit;

  assign req_valid = Hsel_APB && (Htrans == HTRANS_NONSEQ || Htrans == HTRANS_SEQ);
  assign accept    = req_valid && hready_q && (state_q == ST_IDLE || state_q == ST_ERR2);
  assign tmo_hit   = (TIMEOUT != 0) && (tcnt_q == CNT_W'(TIMEOUT - 1));

  apb_decoder #(
    .ADDR_W      (ADDR_W),
    .NUM_SLAVES  (NUM_SLAVES),
    .SLV_SEL_LSB (SLV_SEL_LSB),
    .IDX_W       (IDX_W)
  ) u_decoder (
    .Haddr (Haddr[ADDR_W-1:SLV_SEL_LSB]),
    .valid (req_valid),
    .index (dec_idx),
    .sel   (dec_sel),
    .miss  (dec_miss)
  );

  always_comb begin
    slv_rdata = '0;
    slv_ready = 1'b0;
    slv_err   = 1'b0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (idx_q == IDX_W'(i)) begin
        slv_rdata = Prdata[i*DATA_W +: DATA_W];
        slv_ready = Pready[i];
        slv_err   = Pslverr[i];
      end
    end
  end

  always_ff @(posedge Hclk or posedge Hrst) begin
    if (Hrst) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      miss_q    <= 1'b0;
      sel_q     <= '0;
      psel_q    <= '0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      hrdata_q  <= '0;
      hready_q  <= 1'b1;
      hresp_q   <= HRESP_OKAY;
      tcnt_q    <= '0;
    end else begin
      case (state_q)
        // ERR2 already shows Hready_out=1, so it accepts the next address exactly like IDLE.
        ST_IDLE, ST_ERR2: begin
          state_q  <= ST_IDLE;
          hready_q <= 1'b1;
          hresp_q  <= HRESP_OKAY;
          if (accept) begin
            paddr_q  <= Haddr;
            pwrite_q <= Hwrite;
            idx_q    <= dec_idx;
            sel_q    <= dec_sel;
            miss_q   <= dec_miss;
            hready_q <= 1'b0;
            if (Hwrite) begin
              state_q <= ST_WWAIT;
            end else if (dec_miss) begin
              state_q <= ST_ERR1;
              hresp_q <= HRESP_ERROR;
            end else begin
              state_q <= ST_SETUP;
              psel_q  <= dec_sel;
            end
          end
        end
        ST_WWAIT: begin
          pwdata_q <= Hwdata;
          if (miss_q) begin
            state_q <= ST_ERR1;
            hresp_q <= HRESP_ERROR;
          end else begin
            state_q <= ST_SETUP;
            psel_q  <= sel_q;
          end
        end
        ST_SETUP: begin
          state_q   <= ST_ACCESS;
          penable_q <= 1'b1;
          tcnt_q    <= '0;
        end
        // A ready slave takes priority over a timeout expiring in the same cycle.
        ST_ACCESS: begin
          if (slv_ready || tmo_hit) begin
            psel_q    <= '0;
            penable_q <= 1'b0;
          end
          if (slv_ready && !slv_err) begin
            state_q  <= ST_IDLE;
            hready_q <= 1'b1;
            if (!pwrite_q) begin
              hrdata_q <= slv_rdata;
            end
          end else if (slv_ready || tmo_hit) begin
            state_q <= ST_ERR1;
            hresp_q <= HRESP_ERROR;
          end else begin
            tcnt_q <= tcnt_q + 1'b1;
          end
        end
        ST_ERR1: begin
          state_q  <= ST_ERR2;
          hready_q <= 1'b1;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign Hready_out = hready_q;
  assign Hresp      = hresp_q;
  assign Hrdata     = hrdata_q;
  assign Pselx      = psel_q;
  assign Penable    = penable_q;
  assign Pwrite     = pwrite_q;
  assign Paddr      = paddr_q;
  assign Pwdata     = pwdata_q;

endmodule

// File: tb/tb_ahb_apb_bridge_mc.sv
// Bench for ahb_apb_bridge_mc: directed vector table, reset corner sequence and random traffic against a transfer-level model.
module tb_ahb_apb_bridge_mc;
  import ahb_apb_pkg::*;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int NS  = 4;
  localparam int LSB = 12;
  localparam int TMO = 16;

  logic             Hclk = 1'b0;
  logic             Hrst;
  logic             Hsel_APB;
  logic [1:0]       Htrans;
  logic             Hwrite;
  logic [AW-1:0]    Haddr;
  logic [DW-1:0]    Hwdata;
  logic             Hready_out;
  logic [1:0]       Hresp;
  logic [DW-1:0]    Hrdata;
  logic [NS-1:0]    Pselx;
  logic             Penable;
  logic             Pwrite;
  logic [AW-1:0]    Paddr;
  logic [DW-1:0]    Pwdata;
  logic [NS*DW-1:0] Prdata;
  logic [NS-1:0]    Pready;
  logic [NS-1:0]    Pslverr;

  int            compared    = 0;
  int            mismatched  = 0;
  logic [DW-1:0] modelHrdata = '0;

  typedef struct {
    logic        hsel;
    logic [1:0]  trans;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          waitN;
    logic        err;
    logic [31:0] rdata;
    int          expLat;
    logic        expErr;
    logic [3:0]  expSel;
  } vec_t;

  vec_t tbl [18];

  always #5 Hclk = ~Hclk;

  ahb_apb_bridge_mc #(
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .NUM_SLAVES  (NS),
    .SLV_SEL_LSB (LSB),
    .TIMEOUT     (TMO)
  ) dut (
    .Hclk       (Hclk),
    .Hrst       (Hrst),
    .Hsel_APB   (Hsel_APB),
    .Htrans     (Htrans),
    .Hwrite     (Hwrite),
    .Haddr      (Haddr),
    .Hwdata     (Hwdata),
    .Hready_out (Hready_out),
    .Hresp      (Hresp),
    .Hrdata     (Hrdata),
    .Pselx      (Pselx),
    .Penable    (Penable),
    .Pwrite     (Pwrite),
    .Paddr      (Paddr),
    .Pwdata     (Pwdata),
    .Prdata     (Prdata),
    .Pready     (Pready),
    .Pslverr    (Pslverr)
  );

  function automatic vec_t mk(input logic hsel, input logic [1:0] trans, input logic wr,
                              input logic [31:0] addr, input logic [31:0] wdata, input int waitN,
                              input logic err, input logic [31:0] rdata, input int lat,
                              input logic expErr, input logic [3:0] expSel);
    vec_t r;
    r.hsel = hsel; r.trans = trans; r.wr = wr; r.addr = addr; r.wdata = wdata;
    r.waitN = waitN; r.err = err; r.rdata = rdata;
    r.expLat = lat; r.expErr = expErr; r.expSel = expSel;
    return r;
  endfunction

  // Transfer-level model: latency is a fixed cost per direction plus one cycle per wait state.
  function automatic vec_t modelExpect(input vec_t v);
    vec_t        r;
    logic [19:0] up;
    int          start;
    r  = v;
    up = v.addr[AW-1:LSB];
    start = v.wr ? 3 : 2;
    r.expSel = 4'b0;
    r.expErr = 1'b0;
    if (!(v.hsel && v.trans[1])) begin
      r.expLat = 0;
    end else if (up >= 20'd4) begin
      r.expErr = 1'b1;
      r.expLat = start;
    end else begin
      r.expSel = 4'b0001 << up[1:0];
      if (v.waitN >= TMO) begin
        r.expErr = 1'b1;
        r.expLat = start + TMO + 1;
      end else if (v.err) begin
        r.expErr = 1'b1;
        r.expLat = start + v.waitN + 2;
      end else begin
        r.expLat = start + v.waitN + 1;
      end
    end
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic driveSlaves(input vec_t v, input logic [1:0] slv, input logic inRange, input logic rdy);
    for (int i = 0; i < NS; i++) begin
      if (inRange && i == int'(slv)) begin
        Prdata[i*DW +: DW] = v.rdata;
        Pready[i]          = rdy;
        Pslverr[i]         = v.err;
      end else begin
        Prdata[i*DW +: DW] = $urandom;
        Pready[i]          = 1'($urandom_range(0, 1));
        Pslverr[i]         = 1'($urandom_range(0, 1));
      end
    end
  endtask

  // Called at #1 after an edge in a cycle with Hready_out=1; returns in the completing cycle.
  task automatic applyStimulus(input vec_t v, input string name);
    logic [1:0] slv;
    logic       inRange;
    logic       rdy;
    logic       selBad;
    logic       accBad;
    int         accCnt;
    int         lat;
    int         pselCnt;
    int         penCnt;
    int         errCycles;
    int         expAcc;
    slv     = v.addr[LSB+1:LSB];
    inRange = (v.addr[AW-1:LSB] < 20'd4);
    accCnt = 0; lat = 0; pselCnt = 0; penCnt = 0; errCycles = 0;
    selBad = 1'b0; accBad = 1'b0;
    Hsel_APB = v.hsel; Htrans = v.trans; Hwrite = v.wr; Haddr = v.addr;
    driveSlaves(v, slv, inRange, 1'($urandom_range(0, 1)));
    @(posedge Hclk); #1;
    Hsel_APB = 1'b0; Htrans = HTRANS_IDLE; Hwdata = v.wdata;
    if (v.expLat == 0) begin
      checkOutput($sformatf("%s.ignored", name), {Hready_out, Pselx, Penable, Hresp},
                  {1'b1, 4'b0000, 1'b0, HRESP_OKAY});
    end else begin
      for (int c = 1; c <= 80 && lat == 0; c++) begin
        if (Pselx != 4'b0000) begin
          pselCnt++;
          if (Pselx != v.expSel) selBad = 1'b1;
        end
        if (Penable) begin
          penCnt++;
          if (Pselx == 4'b0000 || Paddr != v.addr || Pwrite != v.wr || (v.wr && Pwdata != v.wdata))
            accBad = 1'b1;
        end
        if (Hresp == HRESP_ERROR) errCycles++;
        if (Hready_out) begin
          lat = c;
        end else begin
          rdy = 1'($urandom_range(0, 1));
          if (Penable) begin
            rdy = (accCnt >= v.waitN);
            accCnt++;
          end
          driveSlaves(v, slv, inRange, rdy);
          Hsel_APB = 1'($urandom_range(0, 1));
          Htrans   = 2'($urandom_range(0, 3));
          Hwrite   = 1'($urandom_range(0, 1));
          Haddr    = $urandom;
          @(posedge Hclk); #1;
        end
      end
      expAcc = (inRange && v.hsel && v.trans[1]) ? ((v.waitN >= TMO) ? TMO : v.waitN + 1) : 0;
      checkOutput($sformatf("%s.latency", name), lat, v.expLat);
      checkOutput($sformatf("%s.hresp", name), Hresp, v.expErr ? HRESP_ERROR : HRESP_OKAY);
      checkOutput($sformatf("%s.errCycles", name), errCycles, v.expErr ? 2 : 0);
      checkOutput($sformatf("%s.pselCycles", name), pselCnt, (expAcc == 0) ? 0 : expAcc + 1);
      checkOutput($sformatf("%s.penableCycles", name), penCnt, expAcc);
      checkOutput($sformatf("%s.pselValue", name), selBad, 0);
      checkOutput($sformatf("%s.apbFields", name), accBad, 0);
      if (!v.wr && !v.expErr) modelHrdata = v.rdata;
      checkOutput($sformatf("%s.hrdata", name), Hrdata, modelHrdata);
    end
    Hsel_APB = 1'b0; Htrans = HTRANS_IDLE;
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: time limit exceeded, got stuck run, expected completion");
    $fatal(1);
  end

  initial begin
    tbl[0]  = mk(1, HTRANS_NONSEQ, 0, 32'h0000_1020, 32'h0,    0,   0, 32'h0000_0010, 3,  0, 4'b0010);
    tbl[1]  = mk(1, HTRANS_NONSEQ, 1, 32'h0000_3004, 32'hFF,   0,   0, 32'h0,         4,  0, 4'b1000);
    tbl[2]  = mk(1, HTRANS_NONSEQ, 0, 32'h0000_0000, 32'h0,    0,   0, 32'hFFFF_FFFF, 3,  0, 4'b0001);
    tbl[3]  = mk(1, HTRANS_SEQ,    0, 32'h0000_0004, 32'h0,    2,   0, 32'hFFFF_FFFB, 5,  0, 4'b0001);
    tbl[4]  = mk(1, HTRANS_SEQ,    0, 32'h0000_0008, 32'h0,    0,   0, 32'hFFFF_FFF8, 3,  0, 4'b0001);
    tbl[5]  = mk(1, HTRANS_SEQ,    0, 32'h0000_000C, 32'h0,    0,   0, 32'hFFFF_FFF4, 3,  0, 4'b0001);
    tbl[6]  = mk(1, HTRANS_NONSEQ, 1, 32'h0000_2000, 32'hA5A5, 0,   1, 32'h0,         5,  1, 4'b0100);
    tbl[7]  = mk(1, HTRANS_NONSEQ, 0, 32'h0000_5000, 32'h0,    0,   0, 32'h0,         2,  1, 4'b0000);
    tbl[8]  = mk(1, HTRANS_NONSEQ, 1, 32'h0000_5000, 32'h1234, 0,   0, 32'h0,         3,  1, 4'b0000);
    tbl[9]  = mk(1, HTRANS_NONSEQ, 0, 32'h0000_1000, 32'h0,    0,   0, 32'h1234_5678, 3,  0, 4'b0010);
    tbl[10] = mk(1, HTRANS_NONSEQ, 0, 32'h0000_3008, 32'h0,    100, 0, 32'hBAD0_0001, 19, 1, 4'b1000);
    tbl[11] = mk(1, HTRANS_NONSEQ, 0, 32'h0000_3000, 32'h0,    15,  0, 32'hCAFE_0001, 18, 0, 4'b1000);
    tbl[12] = mk(1, HTRANS_NONSEQ, 1, 32'h0000_1100, 32'h55,   16,  0, 32'h0,         20, 1, 4'b0010);
    tbl[13] = mk(1, HTRANS_NONSEQ, 1, 32'h0000_2200, 32'h66,   15,  1, 32'h0,         20, 1, 4'b0100);
    tbl[14] = mk(1, HTRANS_BUSY,   0, 32'h0000_1000, 32'h0,    0,   0, 32'h0,         0,  0, 4'b0000);
    tbl[15] = mk(0, HTRANS_NONSEQ, 0, 32'h0000_1000, 32'h0,    0,   0, 32'h0,         0,  0, 4'b0000);
    tbl[16] = mk(1, HTRANS_NONSEQ, 0, 32'h0000_0040, 32'h0,    1,   1, 32'hDEAD_BEEF, 5,  1, 4'b0001);
    tbl[17] = mk(1, HTRANS_SEQ,    0, 32'hFFFF_F000, 32'h0,    0,   0, 32'h0,         2,  1, 4'b0000);

    Hrst = 1'b1; Hsel_APB = 1'b0; Htrans = HTRANS_IDLE; Hwrite = 1'b0;
    Haddr = '0; Hwdata = '0; Prdata = '0; Pready = '0; Pslverr = '0;
    repeat (2) @(posedge Hclk);
    #1;
    checkOutput("reset.ctrl", {Hready_out, Hresp, Pselx, Penable, Pwrite}, {1'b1, 2'b00, 4'b0000, 1'b0, 1'b0});
    checkOutput("reset.hrdata", Hrdata, 0);
    checkOutput("reset.paddr", Paddr, 0);
    checkOutput("reset.pwdata", Pwdata, 0);
    Hrst = 1'b0;
    @(posedge Hclk); #1;

    for (int i = 0; i < 18; i++) begin
      applyStimulus(tbl[i], $sformatf("vec%0d", i));
    end

    // Reset asserted mid-ACCESS must clear the APB strobes without waiting for an edge.
    Hsel_APB = 1'b1; Htrans = HTRANS_NONSEQ; Hwrite = 1'b0; Haddr = 32'h0000_2010;
    Pready = '0; Pslverr = '0;
    @(posedge Hclk); #1;
    Hsel_APB = 1'b0; Htrans = HTRANS_IDLE;
    repeat (3) @(posedge Hclk);
    #1;
    checkOutput("rstMid.inAccess", {Pselx, Penable}, {4'b0100, 1'b1});
    #3;
    Hrst = 1'b1;
    #1;
    checkOutput("rstMid.async", {Hready_out, Hresp, Pselx, Penable, Hrdata},
                {1'b1, 2'b00, 4'b0000, 1'b0, 32'h0});
    modelHrdata = '0;
    @(posedge Hclk); #1;
    Hrst = 1'b0;
    @(posedge Hclk); #1;
    applyStimulus(mk(1, HTRANS_NONSEQ, 0, 32'h0000_2010, 32'h0, 0, 0, 32'h0000_0077, 3, 0, 4'b0100),
                  "rstMid.after");

    for (int n = 0; n < 60; n++) begin
      vec_t        v;
      logic [19:0] up;
      int          pick;
      pick    = $urandom_range(0, 5);
      up      = (pick < 4) ? 20'(pick) : 20'($urandom_range(4, 20'hFFFFF));
      v.addr  = {up, 12'($urandom)};
      v.wr    = 1'($urandom_range(0, 1));
      v.wdata = $urandom;
      v.rdata = $urandom;
      v.err   = ($urandom_range(0, 4) == 0);
      pick    = $urandom_range(0, 9);
      v.waitN = (pick < 7) ? $urandom_range(0, 2) : (pick == 7) ? 15 : (pick == 8) ? 16 : $urandom_range(3, 6);
      v.hsel  = ($urandom_range(0, 15) != 0);
      v.trans = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 1)) : 2'($urandom_range(2, 3));
      v       = modelExpect(v);
      applyStimulus(v, $sformatf("rnd%0d", n));
    end

    Hsel_APB = 1'b0; Htrans = HTRANS_IDLE;
    repeat (2) @(posedge Hclk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/ahb_apb_bridge_mc.md
# ahb_apb_bridge_mc

Parametrised AHB-Lite to APB bridge driving up to NUM_SLAVES APB peripherals behind a single AHB slave select. It extends the single-slave bridge state machine with:
- address decode to a one-hot Pselx,
- PREADY wait states,
- PSLVERR and decode-miss mapped to a two-cycle AHB ERROR response,
- a programmable APB timeout.

It sits between the AHB fabric and the peripheral APB segment.

## Interface
Parameters:
- ADDR_W, 32, address width of Haddr/Paddr
- DATA_W, 32, data width of all data buses
- NUM_SLAVES, 4, APB slaves, 1..16
- SLV_SEL_LSB, 12, slave index = Haddr[ADDR_W-1:SLV_SEL_LSB]; decode miss if index >= NUM_SLAVES
- TIMEOUT, 16, max ACCESS cycles with Pready low before abort; 0 disables

Ports:
- Hclk  in  1  clock, all logic on rising edge
- Hrst  in  1  reset, asynchronous, active-high
- Hsel_APB  in  1  bridge select
- Htrans  in  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11
- Hwrite  in  1  1=write
- Haddr  in  ADDR_W  AHB address
- Hwdata  in  DATA_W  AHB write data (data phase)
- Hready_out  out  1  transfer done / address accepted
- Hresp  out  2  OKAY=00, ERROR=01
- Hrdata  out  DATA_W  registered read data
- Pselx  out  NUM_SLAVES  one-hot APB select
- Penable  out  1  APB access phase
- Pwrite  out  1  APB direction
- Paddr  out  ADDR_W  APB address
- Pwdata  out  DATA_W  APB write data
- Prdata  in  NUM_SLAVES*DATA_W  slave i occupies bits [i*DATA_W +: DATA_W]
- Pready  in  NUM_SLAVES  per-slave ready
- Pslverr  in  NUM_SLAVES  per-slave error

## Operation
- Accept: in IDLE or ERR2, when Hsel_APB & Htrans[1] & Hready_out. On accept, register Haddr, Hwrite and the decoded index. BUSY and IDLE transfers are ignored (OKAY, no APB activity).
- States:
  - IDLE: Hready_out=1.
  - WWAIT: write only; Hready_out=0; capture Hwdata into Pwdata.
  - SETUP: Pselx[idx]=1, Penable=0.
  - ACCESS: Pselx[idx]=1, Penable=1.
  - ERR1: Hready_out=0, Hresp=ERROR.
  - ERR2: Hready_out=1, Hresp=ERROR.
- Transitions:
  - IDLE -> WWAIT on a write accept.
  - IDLE -> SETUP on a read accept.
  - Any accept with a decode miss -> ERR1 (write data is still captured in WWAIT first; no Pselx is ever asserted).
  - WWAIT -> SETUP.
  - SETUP -> ACCESS.
  - ACCESS stays while Pready[idx]=0.
  - ACCESS with Pready[idx]=1 and Pslverr[idx]=0 -> IDLE (OKAY).
  - ACCESS with Pready[idx]=1 and Pslverr[idx]=1 -> ERR1.
  - ACCESS at timeout -> ERR1.
  - ERR1 -> ERR2.
  - ERR2 -> IDLE, or to WWAIT/SETUP if a transfer is accepted in ERR2.
- Read data: on read completion, Hrdata <= Prdata[idx]. Hrdata holds its value otherwise and is not updated on error.
- Outputs between transfers: Paddr, Pwrite and Pwdata hold their last values. Pselx and Penable are 0 outside SETUP/ACCESS.
- Timeout counter: cleared on entering ACCESS; increments each ACCESS cycle with Pready[idx]=0. Abort when count == TIMEOUT-1 with Pready still low. Pselx and Penable drop on the abort edge.
- Pready and Pslverr are ignored outside ACCESS and for non-selected slaves.

## Timing
- Reset values: Hready_out=1, Hresp=00, Hrdata=0, Pselx=0, Penable=0, Pwrite=0, Paddr=0, Pwdata=0, state=IDLE, timeout counter=0.
- Read, zero-wait (address accepted cycle N): SETUP N+1, ACCESS N+2, IDLE with Hready_out=1 and Hrdata valid N+3.
- Write, zero-wait: WWAIT N+1, SETUP N+2, ACCESS N+3, Hready_out=1 N+4.
- Each Pready-low cycle adds one cycle of latency.
- Error: ERR1 one cycle, then ERR2 one cycle.
- Back-to-back and SEQ bursts: each beat is a full APB transfer. The next address is sampled in the cycle Hready_out=1, with no idle gap.
- Reset mid-transfer: all outputs return to reset values asynchronously. The APB transfer is abandoned, with no completion cycle.
- Simultaneous Pready=1 and timeout expiry: Pready wins, and the transfer completes normally.

## Structure
- Shared package ahb_apb_pkg holds:
  - HTRANS and HRESP encodings,
  - the state enum (IDLE, WWAIT, SETUP, ACCESS, ERR1, ERR2),
  - a clog2-based index width helper.
- Sub-module apb_decoder is purely combinational:
  - inputs: Haddr, valid;
  - outputs: index, one-hot select, miss.
- Top level holds the FSM, the timeout counter and the Prdata/Pready/Pslverr muxes.

## Test plan
- Single read, NUM_SLAVES=4, Haddr=0x0000_1020, slave1 Prdata=0x0000_0010, Pready=1 -> Pselx=0010 in N+1..N+2, Penable in N+2, Hrdata=0x10 with Hready_out=1 at N+3, Hresp=OKAY.
- Single write to Haddr=0x0000_3004, Hwdata=0xFF in N+1 -> Pselx=1000, Pwrite=1, Pwdata=0xFF in N+2..N+3, Hready_out=1 at N+4.
- Four-beat SEQ read to slave0 with Pready low for 2 cycles on beat 2 -> beat 2 latency 5 cycles, others 3; data 0xFFFF_FFFF, 0xFFFF_FFFB, 0xFFFF_FFF8, 0xFFFF_FFF4 in order.
- Error cases, each -> Hresp=ERROR for exactly 2 cycles with Hready_out 0 then 1:
  - Pslverr=1 with Pready=1 on a write;
  - decode miss at Haddr=0x0000_5000 (no Pselx asserted).
- TIMEOUT=16, Pready held low -> Penable drops after 16 ACCESS cycles, then ERR1/ERR2.
- Hrst asserted during ACCESS -> Pselx=0, Penable=0, Hready_out=1 without waiting for a clock edge; the next transfer completes normally.
